// File: rtl/load_store_sequencer_if.sv
// Core load/store request bus and word-wide data-memory req/ack bus of the load/store sequencer.
interface load_store_sequencer_if;
    logic        Req;
    logic        WE;
    logic [2:0]  Type;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        Busy;
    logic        Valid;
    logic [31:0] RD;
    logic        Fault;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [3:0]  MemBE;
    logic [31:0] MemWD;
    logic        MemAck;
    logic [31:0] MemRD;

    modport master (
        output Req, WE, Type, Addr, WD, MemAck, MemRD,
        input  Busy, Valid, RD, Fault, MemReq, MemWE, MemAddr, MemBE, MemWD
    );

    modport slave (
        input  Req, WE, Type, Addr, WD, MemAck, MemRD,
        output Busy, Valid, RD, Fault, MemReq, MemWE, MemAddr, MemBE, MemWD
    );
endinterface

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: turns funct3 byte/half/word accesses into aligned word transactions,
// splitting misaligned accesses into two words and reporting illegal types and timeouts as Fault.
//
// state | meaning
// IDLE  | waiting for Req; rejected requests complete directly from here with Fault
// ACC0  | first (or only) aligned word access outstanding
// ACC1  | second word of a split access outstanding
module load_store_sequencer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter bit          SPLIT_EN = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    load_store_sequencer_if.slave bus
);
    localparam int unsigned   CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] TC = CW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_t;

    state_t        state;
    logic          we_q;
    logic [2:0]    type_q;
    logic [1:0]    a_q;
    logic [3:0]    mask_hi;
    logic [31:0]   wd_hi;
    logic [31:0]   lo_q;
    logic [CW-1:0] wait_cnt;

    logic [1:0]    req_a;
    logic [7:0]    req_base;
    logic [7:0]    req_mask;
    logic [63:0]   req_data;
    logic          req_illegal;
    logic          req_split;
    logic          req_reject;
    logic          timeout;
    logic [31:0]   ld_aligned;
    logic [31:0]   ld_split;

    function automatic logic [31:0] extend_load(input logic [2:0]  t,
                                                input logic [1:0]  a,
                                                input logic [63:0] w);
        logic [63:0] x;
        x = w >> {a, 3'b000};
        case (t)
            3'b000:  return {{24{x[7]}}, x[7:0]};
            3'b100:  return {24'b0, x[7:0]};
            3'b001:  return {{16{x[15]}}, x[15:0]};
            3'b101:  return {16'b0, x[15:0]};
            default: return x[31:0];
        endcase
    endfunction

    always_comb begin
        req_a = bus.Addr[1:0];
        case (bus.Type[1:0])
            2'b00:   req_base = 8'h01;
            2'b01:   req_base = 8'h03;
            default: req_base = 8'h0F;
        endcase
        req_mask    = req_base << req_a;
        req_data    = {32'b0, bus.WD} << {req_a, 3'b000};
        req_illegal = (bus.Type == 3'b011) || (bus.Type == 3'b110) || (bus.Type == 3'b111) ||
                      (bus.WE && bus.Type[2]);
        req_split   = |req_mask[7:4];
        req_reject  = req_illegal || (req_split && !SPLIT_EN);
    end

    // Aligned accesses never reach past byte 3, so the upper word is irrelevant there.
    assign ld_aligned = extend_load(type_q, a_q, {32'b0, bus.MemRD});
    assign ld_split   = extend_load(type_q, a_q, {bus.MemRD, lo_q});
    assign timeout    = (MAX_WAIT != 0) && (wait_cnt == TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            type_q      <= 3'b000;
            a_q         <= 2'b00;
            mask_hi     <= 4'b0000;
            wd_hi       <= '0;
            lo_q        <= '0;
            wait_cnt    <= '0;
            bus.Busy    <= 1'b0;
            bus.Valid   <= 1'b0;
            bus.Fault   <= 1'b0;
            bus.RD      <= '0;
            bus.MemReq  <= 1'b0;
            bus.MemWE   <= 1'b0;
            bus.MemAddr <= '0;
            bus.MemBE   <= 4'b0000;
            bus.MemWD   <= '0;
        end else begin
            bus.Valid <= 1'b0;
            bus.Fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Req) begin
                        we_q    <= bus.WE;
                        type_q  <= bus.Type;
                        a_q     <= req_a;
                        mask_hi <= req_mask[7:4];
                        wd_hi   <= req_data[63:32];
                        if (req_reject) begin
                            bus.Valid <= 1'b1;
                            bus.Fault <= 1'b1;
                            bus.RD    <= '0;
                        end else begin
                            state       <= ACC0;
                            bus.Busy    <= 1'b1;
                            bus.MemReq  <= 1'b1;
                            bus.MemWE   <= bus.WE;
                            bus.MemAddr <= {bus.Addr[31:2], 2'b00};
                            bus.MemBE   <= bus.WE ? req_mask[3:0] : 4'b0000;
                            bus.MemWD   <= req_data[31:0];
                            wait_cnt    <= '0;
                        end
                    end
                end
                ACC0: begin
                    if (bus.MemAck) begin
                        lo_q     <= bus.MemRD;
                        wait_cnt <= '0;
                        if (|mask_hi) begin
                            // MemReq stays high straight into the second word.
                            state       <= ACC1;
                            bus.MemAddr <= bus.MemAddr + 32'd4;
                            bus.MemBE   <= we_q ? mask_hi : 4'b0000;
                            bus.MemWD   <= wd_hi;
                        end else begin
                            state      <= IDLE;
                            bus.Busy   <= 1'b0;
                            bus.MemReq <= 1'b0;
                            bus.MemWE  <= 1'b0;
                            bus.MemBE  <= 4'b0000;
                            bus.Valid  <= 1'b1;
                            bus.RD     <= we_q ? 32'h0 : ld_aligned;
                        end
                    end else if (timeout) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        bus.Busy   <= 1'b0;
                        bus.MemReq <= 1'b0;
                        bus.MemWE  <= 1'b0;
                        bus.MemBE  <= 4'b0000;
                        bus.Valid  <= 1'b1;
                        bus.Fault  <= 1'b1;
                        bus.RD     <= '0;
                    end else if (MAX_WAIT != 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ACC1: begin
                    if (bus.MemAck) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        bus.Busy   <= 1'b0;
                        bus.MemReq <= 1'b0;
                        bus.MemWE  <= 1'b0;
                        bus.MemBE  <= 4'b0000;
                        bus.Valid  <= 1'b1;
                        bus.RD     <= we_q ? 32'h0 : ld_split;
                    end else if (timeout) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        bus.Busy   <= 1'b0;
                        bus.MemReq <= 1'b0;
                        bus.MemWE  <= 1'b0;
                        bus.MemBE  <= 4'b0000;
                        bus.Valid  <= 1'b1;
                        bus.Fault  <= 1'b1;
                        bus.RD     <= '0;
                    end else if (MAX_WAIT != 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.Busy   <= 1'b0;
                    bus.MemReq <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: completions are scoreboarded, and a scripted memory
// responder checks every memory access against hand-computed address/enables/data.
module tb_load_store_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_sequencer_if bus();
    load_store_sequencer #(.MAX_WAIT(16), .SPLIT_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] rd; logic fault; int cyc; } sb_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wd; } mem_t;
    typedef struct { logic [2:0] t; logic [31:0] a; logic [31:0] rd; } ld_vec_t;

    sb_t         sb_q[$];
    mem_t        mem_q[$];
    logic [31:0] rd_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          req_cycles = 0;
    logic        mem_auto = 1'b1;
    logic        man_ack = 1'b0;
    logic [31:0] man_rd = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd);
        mem_t m;
        m.addr = a; m.we = we; m.be = be; m.wd = wd;
        mem_q.push_back(m);
        rd_q.push_back(rd);
    endtask

    // lat < 0: no completion expected (access is cut short by reset)
    task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd_exp, input logic f_exp,
                         input int lat, output int c_issue);
        sb_t e;
        while (bus.Busy) @(negedge clk);
        c_issue = cyc;
        if (lat >= 0) begin
            e.rd = rd_exp; e.fault = f_exp; e.cyc = cyc + lat;
            sb_q.push_back(e);
        end
        bus.Req = 1'b1; bus.WE = we; bus.Type = t; bus.Addr = a; bus.WD = wd;
        @(negedge clk);
        bus.Req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || bus.Busy) && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL %s_drain: got %0d pending completions after 100 cycles, expected 0", name, sb_q.size());
            sb_q.delete();
        end
        check({name, "_mem_left"}, 64'(mem_q.size()), 64'd0);
        mem_q.delete();
        rd_q.delete();
    endtask

    // Completion monitor
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.Valid) begin
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: got RD=%0h Fault=%b, expected no completion", bus.RD, bus.Fault);
                end else begin
                    e = sb_q.pop_front();
                    check("valid_RD", 64'(bus.RD), 64'(e.rd));
                    check("valid_Fault", 64'(bus.Fault), 64'(e.fault));
                    check("valid_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Memory responder
    initial begin
        int          wait_ctr = 0;
        bit          prev_v = 0;
        logic [31:0] prev_addr = '0;
        logic [36:0] prev_ctl = '0;
        mem_t        m;
        bus.MemAck = 1'b0;
        bus.MemRD  = 32'h0;
        forever begin
            @(negedge clk); #1;
            if (!mem_auto) begin
                bus.MemAck = man_ack; bus.MemRD = man_rd; prev_v = 0; wait_ctr = 0;
            end else if (bus.MemReq && !rst) begin
                req_cycles++;
                if (prev_v) begin
                    check("mem_stable_addr", 64'(bus.MemAddr), 64'(prev_addr));
                    check("mem_stable_ctl", 64'({bus.MemWE, bus.MemBE, bus.MemWD}), 64'(prev_ctl));
                end
                if (wait_ctr >= ack_delay) begin
                    bus.MemAck = 1'b1;
                    bus.MemRD  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                    if (mem_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_mem_access: got MemAddr=%0h, expected no access", bus.MemAddr);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_addr", 64'(bus.MemAddr), 64'(m.addr));
                        check("mem_we_be_wd", 64'({bus.MemWE, bus.MemBE, bus.MemWD}), 64'({m.we, m.be, m.wd}));
                    end
                    wait_ctr = 0; prev_v = 0;
                end else begin
                    bus.MemAck = 1'b0;
                    wait_ctr++;
                    prev_v = 1; prev_addr = bus.MemAddr; prev_ctl = {bus.MemWE, bus.MemBE, bus.MemWD};
                end
            end else begin
                bus.MemAck = 1'b0; wait_ctr = 0; prev_v = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int      c, c_prev;
        ld_vec_t lv[5];
        logic [2:0] bad_t[5];
        logic       bad_we[5];

        bus.Req = 1'b0; bus.WE = 1'b0; bus.Type = 3'b000; bus.Addr = '0; bus.WD = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({bus.Busy, bus.Valid, bus.Fault, bus.MemReq, bus.MemWE, bus.MemBE}), 64'd0);
        check("rst_RD", 64'(bus.RD), 64'd0);
        check("rst_MemAddr", 64'(bus.MemAddr), 64'd0);
        check("rst_MemWD", 64'(bus.MemWD), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // aligned word load
        exp_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, c);
        drain("lw_aligned");

        // byte/half loads issued back-to-back
        lv[0] = '{3'b000, 32'h201, 32'h0000007F};
        lv[1] = '{3'b100, 32'h203, 32'h00000080};
        lv[2] = '{3'b000, 32'h203, 32'hFFFFFF80};
        lv[3] = '{3'b001, 32'h202, 32'hFFFF80FF};
        lv[4] = '{3'b101, 32'h200, 32'h00007F01};
        c_prev = 0;
        for (int i = 0; i < 5; i++) begin
            exp_mem(32'h200, 1'b0, 4'b0000, 32'h0, 32'h80FF7F01);
            issue(1'b0, lv[i].t, lv[i].a, 32'h0, lv[i].rd, 1'b0, 2, c);
            if (i > 0) check("b2b_issue_cycle", 64'(c), 64'(c_prev + 2));
            c_prev = c;
        end
        drain("ld_sub");

        // misaligned word load split
        exp_mem(32'h100, 1'b0, 4'b0000, 32'h0, 32'h44332211);
        exp_mem(32'h104, 1'b0, 4'b0000, 32'h0, 32'h88776655);
        issue(1'b0, 3'b010, 32'h103, 32'h0, 32'h77665544, 1'b0, 3, c);
        drain("lw_split");

        // split half load wrapping past the top of the address space
        exp_mem(32'hFFFFFFFC, 1'b0, 4'b0000, 32'h0, 32'h11223344);
        exp_mem(32'h00000000, 1'b0, 4'b0000, 32'h0, 32'h55667788);
        issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFF8811, 1'b0, 3, c);
        drain("lh_wrap");

        // stores
        exp_mem(32'h40, 1'b1, 4'b1111, 32'h12345678, 32'hFFFFFFFF);
        issue(1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0, 1'b0, 2, c);
        exp_mem(32'h40, 1'b1, 4'b0100, 32'hFFA50000, 32'hFFFFFFFF);
        issue(1'b1, 3'b000, 32'h42, 32'hFFFFFFA5, 32'h0, 1'b0, 2, c);
        exp_mem(32'h4, 1'b1, 4'b1100, 32'hABCD0000, 32'hFFFFFFFF);
        issue(1'b1, 3'b001, 32'h6, 32'h1234ABCD, 32'h0, 1'b0, 2, c);
        drain("st_aligned");
        exp_mem(32'h0, 1'b1, 4'b1000, 32'hCD000000, 32'hFFFFFFFF);
        exp_mem(32'h4, 1'b1, 4'b0001, 32'h000000AB, 32'hFFFFFFFF);
        issue(1'b1, 3'b001, 32'h3, 32'h0000ABCD, 32'h0, 1'b0, 3, c);
        drain("sh_split");
        exp_mem(32'h40, 1'b1, 4'b1110, 32'h22334400, 32'hFFFFFFFF);
        exp_mem(32'h44, 1'b1, 4'b0001, 32'h00000011, 32'hFFFFFFFF);
        issue(1'b1, 3'b010, 32'h41, 32'h11223344, 32'h0, 1'b0, 3, c);
        drain("sw_split");

        // illegal types: fault next cycle, no memory access
        bad_t  = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b101};
        bad_we = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            issue(bad_we[i], bad_t[i], 32'h100, 32'h5A5A5A5A, 32'h0, 1'b1, 1, c);
        end
        drain("illegal");

        // timeout: ack never arrives
        ack_delay = 1000;
        req_cycles = 0;
        issue(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b1, 17, c);
        drain("timeout");
        check("timeout_req_cycles", 64'(req_cycles), 64'd16);
        check("timeout_memreq_low", 64'(bus.MemReq), 64'd0);

        // ack in the last permitted cycle still completes
        ack_delay = 15;
        exp_mem(32'h600, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h600, 32'h0, 32'hCAFEF00D, 1'b0, 17, c);
        drain("late_ack");
        ack_delay = 0;

        // reset during the second word, ack arriving just after reset
        mem_auto = 1'b0;
        man_ack  = 1'b0;
        issue(1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b0, -1, c);
        check("rst_mid_acc0_addr", 64'(bus.MemAddr), 64'h0);
        man_ack = 1'b1; man_rd = 32'h12345678;
        @(negedge clk);
        man_ack = 1'b0;
        check("rst_mid_acc1_addr", 64'(bus.MemAddr), 64'h4);
        check("rst_mid_acc1_req", 64'({bus.MemReq, bus.Busy}), 64'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        man_ack = 1'b1; man_rd = 32'h9ABCDEF0;
        check("rst_mid_ctrl", 64'({bus.Busy, bus.Valid, bus.Fault, bus.MemReq, bus.MemWE, bus.MemBE}), 64'd0);
        check("rst_mid_RD", 64'(bus.RD), 64'd0);
        check("rst_mid_MemAddr", 64'(bus.MemAddr), 64'd0);
        check("rst_mid_MemWD", 64'(bus.MemWD), 64'd0);
        @(negedge clk);
        man_ack = 1'b0;
        check("rst_late_ack_ignored", 64'({bus.Busy, bus.Valid, bus.MemReq}), 64'd0);
        @(negedge clk);
        check("rst_no_valid", 64'(bus.Valid), 64'd0);
        mem_auto = 1'b1;
        @(negedge clk);
        exp_mem(32'h700, 1'b0, 4'b0000, 32'h0, 32'h0BADF00D);
        issue(1'b0, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 1'b0, 2, c);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
